// File: rtl/npu_intra_mover.sv
// Intra-network mover: streams 32-bit output-buffer rows back into the activation buffer
// as requantized INT8 rows (round-half-up shift, optional ReLU, saturate), 1 row/cycle.
module npu_intra_mover #(
    parameter int ADDR_WIDTH   = 32,
    parameter int ARRAY_N      = 16,
    parameter int ARRAY_M      = 16,
    parameter int PE_OUT_WIDTH = 32
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              start_i,
    input  logic [ADDR_WIDTH-1:0]             o_base_i,
    input  logic [ADDR_WIDTH-1:0]             a_base_i,
    input  logic [$clog2(ARRAY_M):0]          num_rows_i,
    input  logic [$clog2(ARRAY_N):0]          num_cols_i,
    input  logic [4:0]                        shift_i,
    input  logic                              relu_i,
    output logic                              o_rd_en_o,
    output logic [ADDR_WIDTH-1:0]             o_rd_addr_o,
    input  logic [ARRAY_N*PE_OUT_WIDTH-1:0]   o_rd_data_i,
    output logic [ARRAY_N-1:0]                a_wr_en_o,
    output logic [ADDR_WIDTH-1:0]             a_wr_addr_o,
    output logic [ARRAY_N*8-1:0]              a_wr_data_o,
    output logic                              busy_o,
    output logic                              done_o
);

    localparam int RW = $clog2(ARRAY_M) + 1;
    localparam int CW = $clog2(ARRAY_N) + 1;
    localparam int XW = PE_OUT_WIDTH + 1;
    localparam logic signed [XW-1:0] Q_MAX = XW'(127);
    localparam logic signed [XW-1:0] Q_MIN = XW'(-128);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_FLUSH, S_DONE} state_t;

    state_t                r_state;
    logic [RW-1:0]         r_rows;
    logic [RW-1:0]         r_rd_cnt;
    logic [CW-1:0]         r_cols;
    logic [4:0]            r_shift;
    logic                  r_relu;
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic                  r_flush_cnt;
    logic                  r_dat_vld;

    logic [RW-1:0]         w_rows_sat;
    logic [CW-1:0]         w_cols_sat;
    logic signed [XW-1:0]  w_half;
    logic [ARRAY_N-1:0]    w_lane_en;
    logic [ARRAY_N*8-1:0]  w_q;

    assign w_rows_sat = (num_rows_i > RW'(ARRAY_M)) ? RW'(ARRAY_M) : num_rows_i;
    assign w_cols_sat = (num_cols_i > CW'(ARRAY_N)) ? CW'(ARRAY_N) : num_cols_i;
    // Rounding constant 2^(shift-1); only used when shift>0.
    assign w_half     = $signed({{PE_OUT_WIDTH{1'b0}}, 1'b1} << (r_shift - 5'd1));

    genvar gi;
    generate
        for (gi = 0; gi < ARRAY_N; gi++) begin : g_lane
            logic signed [XW-1:0] w_x;
            logic signed [XW-1:0] w_r;
            logic signed [XW-1:0] w_y;
            logic [7:0]           w_q8;

            always_comb begin
                w_x = $signed({o_rd_data_i[(gi+1)*PE_OUT_WIDTH-1],
                               o_rd_data_i[gi*PE_OUT_WIDTH +: PE_OUT_WIDTH]});
                if (r_shift == 5'd0) begin
                    w_r = w_x;
                end else begin
                    w_r = (w_x + w_half) >>> r_shift;
                end
                w_y = (r_relu && w_r[XW-1]) ? '0 : w_r;
                if (w_y > Q_MAX) begin
                    w_q8 = 8'h7F;
                end else if (w_y < Q_MIN) begin
                    w_q8 = 8'h80;
                end else begin
                    w_q8 = w_y[7:0];
                end
            end

            assign w_lane_en[gi]      = (CW'(gi) < r_cols);
            assign w_q[gi*8 +: 8]     = w_lane_en[gi] ? w_q8 : 8'd0;
        end
    endgenerate

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= S_IDLE;
            r_rows      <= '0;
            r_rd_cnt    <= '0;
            r_cols      <= '0;
            r_shift     <= '0;
            r_relu      <= 1'b0;
            r_wr_ptr    <= '0;
            r_flush_cnt <= 1'b0;
            r_dat_vld   <= 1'b0;
            o_rd_en_o   <= 1'b0;
            o_rd_addr_o <= '0;
            a_wr_en_o   <= '0;
            a_wr_addr_o <= '0;
            a_wr_data_o <= '0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
        end else begin
            done_o    <= 1'b0;
            r_dat_vld <= o_rd_en_o;

            // Write stage: read data is on the bus the cycle after the strobe.
            if (r_dat_vld) begin
                a_wr_en_o   <= w_lane_en;
                a_wr_addr_o <= r_wr_ptr;
                a_wr_data_o <= w_q;
                r_wr_ptr    <= r_wr_ptr + ADDR_WIDTH'(1);
            end else begin
                a_wr_en_o   <= '0;
                a_wr_addr_o <= '0;
                a_wr_data_o <= '0;
            end

            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_rows   <= w_rows_sat;
                        r_cols   <= w_cols_sat;
                        r_shift  <= shift_i;
                        r_relu   <= relu_i;
                        r_wr_ptr <= a_base_i;
                        if (w_rows_sat != '0) begin
                            r_state     <= S_READ;
                            busy_o      <= 1'b1;
                            o_rd_en_o   <= 1'b1;
                            o_rd_addr_o <= o_base_i;
                            r_rd_cnt    <= RW'(1);
                        end else begin
                            r_state <= S_DONE;
                            done_o  <= 1'b1;
                        end
                    end
                end
                S_READ: begin
                    if (r_rd_cnt == r_rows) begin
                        o_rd_en_o   <= 1'b0;
                        o_rd_addr_o <= '0;
                        r_flush_cnt <= 1'b0;
                        r_state     <= S_FLUSH;
                    end else begin
                        o_rd_addr_o <= o_rd_addr_o + ADDR_WIDTH'(1);
                        r_rd_cnt    <= r_rd_cnt + RW'(1);
                    end
                end
                S_FLUSH: begin
                    if (r_flush_cnt) begin
                        r_state <= S_DONE;
                        busy_o  <= 1'b0;
                        done_o  <= 1'b1;
                    end else begin
                        r_flush_cnt <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_npu_intra_mover.sv
// Bench for npu_intra_mover: per-cycle comparison against a transaction-level timeline model,
// plus literal checks of latency, requant results, lane masking, busy-start rejection and reset abort.
module tb_npu_intra_mover;

    localparam int NC = 1024;

    logic          clk = 1'b0;
    logic          rst_ni;
    logic          start_i;
    logic [31:0]   o_base_i, a_base_i;
    logic [4:0]    num_rows_i, num_cols_i, shift_i;
    logic          relu_i;
    logic          o_rd_en_o;
    logic [31:0]   o_rd_addr_o;
    logic [511:0]  o_rd_data_i = '0;
    logic [15:0]   a_wr_en_o;
    logic [31:0]   a_wr_addr_o;
    logic [127:0]  a_wr_data_o;
    logic          busy_o, done_o;

    always #5 clk = ~clk;

    npu_intra_mover dut (
        .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i),
        .o_base_i(o_base_i), .a_base_i(a_base_i),
        .num_rows_i(num_rows_i), .num_cols_i(num_cols_i),
        .shift_i(shift_i), .relu_i(relu_i),
        .o_rd_en_o(o_rd_en_o), .o_rd_addr_o(o_rd_addr_o), .o_rd_data_i(o_rd_data_i),
        .a_wr_en_o(a_wr_en_o), .a_wr_addr_o(a_wr_addr_o), .a_wr_data_o(a_wr_data_o),
        .busy_o(busy_o), .done_o(done_o)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Buffers outside the DUT: o-buffer with one-cycle read latency, a-buffer capture.
    logic [511:0] obuf [64];
    logic [127:0] abuf [64];
    always @(posedge clk) if (o_rd_en_o) o_rd_data_i <= obuf[o_rd_addr_o[5:0]];
    always @(posedge clk)
        for (int k = 0; k < 16; k++)
            if (a_wr_en_o[k]) abuf[a_wr_addr_o[5:0]][8*k +: 8] <= a_wr_data_o[8*k +: 8];

    // Expected per-cycle timeline.
    logic         exp_rd_en   [NC];
    logic [31:0]  exp_rd_addr [NC];
    logic [15:0]  exp_wr_en   [NC];
    logic [31:0]  exp_wr_addr [NC];
    logic [127:0] exp_wr_data [NC];
    logic         exp_busy    [NC];
    logic         exp_done    [NC];

    int n_chk = 0, n_pass = 0;
    int rd_count = 0, wr_count = 0, done_count = 0, done_cyc = -1;
    logic [127:0] last_wr_data = '0;
    logic [15:0]  last_wr_en = '0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
    endtask

    function automatic logic [7:0] rq(input int x, input int sh, input bit relu);
        longint y;
        y = x;
        if (sh > 0) y = (y + (longint'(1) << (sh - 1))) >>> sh;
        if (relu && y < 0) y = 0;
        if (y > 127) y = 127;
        if (y < -128) y = -128;
        return y[7:0];
    endfunction

    function automatic logic [127:0] exp_row(input logic [31:0] ob, input int r, input int cols,
                                             input int sh, input bit relu);
        logic [31:0]  a;
        logic [511:0] d;
        logic [127:0] o;
        a = ob + r;
        d = obuf[a[5:0]];
        o = '0;
        for (int k = 0; k < cols; k++) o[8*k +: 8] = rq($signed(d[32*k +: 32]), sh, relu);
        return o;
    endfunction

    always @(negedge clk) begin
        int c;
        c = cyc;
        if (c < NC) begin
            chk("rd_en", 128'(o_rd_en_o), 128'(exp_rd_en[c]));
            if (exp_rd_en[c]) chk("rd_addr", 128'(o_rd_addr_o), 128'(exp_rd_addr[c]));
            chk("wr_en", 128'(a_wr_en_o), 128'(exp_wr_en[c]));
            if (exp_wr_en[c] != 16'h0) begin
                chk("wr_addr", 128'(a_wr_addr_o), 128'(exp_wr_addr[c]));
                chk("wr_data", a_wr_data_o, exp_wr_data[c]);
            end
            chk("busy", 128'(busy_o), 128'(exp_busy[c]));
            chk("done", 128'(done_o), 128'(exp_done[c]));
        end
        if (o_rd_en_o) rd_count++;
        if (a_wr_en_o != 16'h0) begin
            wr_count++;
            last_wr_data = a_wr_data_o;
            last_wr_en   = a_wr_en_o;
        end
        if (done_o) begin
            done_count++;
            done_cyc = c;
        end
    end

    task automatic start_xfer(input string nm, input logic [31:0] ob, input logic [31:0] ab,
                              input int nr, input int nc, input int sh, input bit relu,
                              output int s);
        int rr, cc;
        logic [16:0] m;
        @(negedge clk);
        o_base_i = ob; a_base_i = ab; num_rows_i = 5'(nr); num_cols_i = 5'(nc);
        shift_i = 5'(sh); relu_i = relu; start_i = 1'b1;
        s  = cyc;
        rr = (nr > 16) ? 16 : nr;
        cc = (nc > 16) ? 16 : nc;
        m  = (17'd1 << cc) - 17'd1;
        for (int r = 0; r < rr; r++) begin
            exp_rd_en[s+1+r]   = 1'b1;
            exp_rd_addr[s+1+r] = ob + r;
            exp_wr_en[s+3+r]   = m[15:0];
            exp_wr_addr[s+3+r] = ab + r;
            exp_wr_data[s+3+r] = exp_row(ob, r, cc, sh, relu);
        end
        if (rr > 0) begin
            for (int c = s + 1; c <= s + rr + 2; c++) exp_busy[c] = 1'b1;
            exp_done[s+rr+3] = 1'b1;
        end else begin
            exp_done[s+1] = 1'b1;
        end
        $display("xfer %s: start cycle %0d rows=%0d cols=%0d shift=%0d relu=%0d", nm, s, nr, nc, sh, relu);
        @(negedge clk);
        start_i = 1'b0;
        o_base_i = $urandom; a_base_i = $urandom;
        num_rows_i = 5'($urandom); num_cols_i = 5'($urandom);
        shift_i = 5'($urandom); relu_i = 1'($urandom);
    endtask

    task automatic wait_rows(input int rows);
        repeat (((rows > 16) ? 16 : rows) + 4) @(negedge clk);
    endtask

    initial begin
        int s, rd0, wr0, dn0;
        logic signed [31:0] big [4];
        big[0] = 32'h7FFF_FFFF; big[1] = 32'h8000_0000; big[2] = 32'h4000_0000; big[3] = 32'h3FFF_FFFF;
        for (int c = 0; c < NC; c++) begin
            exp_rd_en[c] = 0; exp_rd_addr[c] = 0; exp_wr_en[c] = 0; exp_wr_addr[c] = 0;
            exp_wr_data[c] = 0; exp_busy[c] = 0; exp_done[c] = 0;
        end
        for (int i = 0; i < 64; i++) begin
            abuf[i] = '0;
            for (int k = 0; k < 16; k++)
                obuf[i][32*k +: 32] = 32'((i * 131 + k * 997) * ((k % 2 == 1) ? -3 : 3));
        end
        for (int r = 0; r < 4; r++)
            for (int k = 0; k < 16; k++) obuf[r][32*k +: 32] = 32'(r * 16 + k);
        obuf[8][127:0]  = {32'(-25), 32'(-24), 32'd24, 32'd23};
        obuf[9][127:0]  = {32'(-129), 32'd127, 32'(-1000), 32'd1000};
        for (int k = 0; k < 16; k++) begin
            obuf[62][32*k +: 32] = big[k % 4];
            obuf[63][32*k +: 32] = big[(k + 1) % 4];
        end

        rst_ni = 1'b0; start_i = 1'b0; o_base_i = '0; a_base_i = '0;
        num_rows_i = '0; num_cols_i = '0; shift_i = '0; relu_i = 1'b0;
        #2;
        chk("reset_ctrl", {o_rd_en_o, busy_o, done_o}, 3'b000);
        chk("reset_wr", {a_wr_en_o, a_wr_data_o}, '0);
        chk("reset_addr", {o_rd_addr_o, a_wr_addr_o}, '0);
        @(negedge clk);
        rst_ni = 1'b1;

        // Model pins straight from the requant rules.
        chk("pin_rq_23", 128'(rq(23, 4, 0)), 128'(8'h01));
        chk("pin_rq_m25", 128'(rq(-25, 4, 0)), 128'(8'hFE));
        chk("pin_rq_1000_relu", 128'(rq(-1000, 0, 1)), 128'(8'h00));

        // T1: plain copy, latency rows+3.
        start_xfer("t1", 32'h100, 32'h2000, 4, 16, 0, 0, s);
        wait_rows(4);
        chk("t1_done_lat", 128'(done_cyc - s), 128'(7));
        chk("t1_row3_lane0", 128'(last_wr_data[7:0]), 128'(8'd48));
        chk("t1_row3_lane15", 128'(last_wr_data[127:120]), 128'(8'd63));

        // T2: rounding.
        start_xfer("t2", 32'h8, 32'h40, 1, 4, 4, 0, s);
        wait_rows(1);
        chk("t2_data", last_wr_data, 128'h0000_0000_0000_0000_0000_0000_FEFF_0201);

        // T3: saturation with and without ReLU.
        start_xfer("t3a", 32'h9, 32'h41, 1, 4, 0, 0, s);
        wait_rows(1);
        chk("t3_sat", last_wr_data, 128'h0000_0000_0000_0000_0000_0000_807F_807F);
        start_xfer("t3b", 32'h9, 32'h42, 1, 4, 0, 1, s);
        wait_rows(1);
        chk("t3_relu", last_wr_data, 128'h0000_0000_0000_0000_0000_0000_007F_007F);

        // T4: 5 lanes, row count saturates from 31 to 16.
        wr0 = wr_count;
        start_xfer("t4", 32'h10, 32'h80, 31, 5, 2, 0, s);
        wait_rows(16);
        chk("t4_writes", 128'(wr_count - wr0), 128'(16));
        chk("t4_lane_en", 128'(last_wr_en), 128'(16'h001F));

        // Address wrap, column saturation, maximal shift with ReLU.
        start_xfer("wrap", 32'hFFFF_FFFE, 32'hFFFF_FFFF, 3, 31, 31, 1, s);
        wait_rows(3);

        // T5: zero rows, start during DONE ignored, start while busy ignored.
        rd0 = rd_count; wr0 = wr_count;
        start_xfer("t5a", 32'h20, 32'h100, 0, 16, 0, 0, s);
        start_i = 1'b1; num_rows_i = 5'd2;
        @(negedge clk);
        start_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("t5_done_lat", 128'(done_cyc - s), 128'(1));
        chk("t5_no_rd", 128'(rd_count - rd0), 128'(0));
        chk("t5_no_wr", 128'(wr_count - wr0), 128'(0));
        rd0 = rd_count;
        start_xfer("t5b", 32'h20, 32'h100, 8, 16, 1, 0, s);
        @(negedge clk);
        start_i = 1'b1; num_rows_i = 5'd3; o_base_i = 32'h30;
        @(negedge clk);
        start_i = 1'b0;
        wait_rows(8);
        chk("t5_busy_start", 128'(rd_count - rd0), 128'(8));

        // T6: asynchronous reset at the third write.
        dn0 = done_count;
        start_xfer("t6", 32'h28, 32'h128, 8, 16, 0, 0, s);
        repeat (4) @(negedge clk);
        for (int c = s + 6; c <= s + 20; c++) begin
            exp_rd_en[c] = 0; exp_wr_en[c] = 0; exp_busy[c] = 0; exp_done[c] = 0;
        end
        #2 rst_ni = 1'b0;
        #1;
        chk("t6_rst_ctrl", {o_rd_en_o, busy_o, done_o}, 3'b000);
        chk("t6_rst_wr", {a_wr_en_o, a_wr_data_o}, '0);
        @(negedge clk);
        @(negedge clk);
        rst_ni = 1'b1;
        repeat (4) @(negedge clk);
        chk("t6_no_done", 128'(done_count - dn0), 128'(0));
        chk("t6_kept_row0", abuf[40], exp_wr_data[s+3]);
        chk("t6_kept_row1", abuf[41], exp_wr_data[s+4]);
        start_xfer("t6r", 32'h100, 32'h300, 4, 16, 0, 0, s);
        wait_rows(4);
        chk("t6r_done_lat", 128'(done_cyc - s), 128'(7));

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
